// File: rtl/axi4_slave_mem_responder_if.sv
// AXI4 bus bundle between the DMA master port and the memory responder.
// Latency: none, this is wiring only.
// Backpressure: carried by the per-channel valid/ready pairs.
interface axi4_slave_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int STRB_W = DATA_W / 8;

  // Write address channel
  logic [ID_W-1:0]   awid_s;
  logic [ADDR_W-1:0] awaddr_s;
  logic [7:0]        awlen_s;
  logic [2:0]        awsize_s;
  logic [1:0]        awburst_s;
  logic              awvalid_s;
  logic              awready_s;

  // Write data channel
  logic [DATA_W-1:0] wdata_s;
  logic [STRB_W-1:0] wstrb_s;
  logic              wlast_s;
  logic              wvalid_s;
  logic              wready_s;

  // Write response channel
  logic [ID_W-1:0]   bid_s;
  logic [1:0]        bresp_s;
  logic              bvalid_s;
  logic              bready_s;

  // Read address channel
  logic [ID_W-1:0]   arid_s;
  logic [ADDR_W-1:0] araddr_s;
  logic [7:0]        arlen_s;
  logic [2:0]        arsize_s;
  logic [1:0]        arburst_s;
  logic              arvalid_s;
  logic              arready_s;

  // Read data channel
  logic [ID_W-1:0]   rid_s;
  logic [DATA_W-1:0] rdata_s;
  logic [1:0]        rresp_s;
  logic              rlast_s;
  logic              rvalid_s;
  logic              rready_s;

  modport master (
    output awid_s, awaddr_s, awlen_s, awsize_s, awburst_s, awvalid_s,
    input  awready_s,
    output wdata_s, wstrb_s, wlast_s, wvalid_s,
    input  wready_s,
    input  bid_s, bresp_s, bvalid_s,
    output bready_s,
    output arid_s, araddr_s, arlen_s, arsize_s, arburst_s, arvalid_s,
    input  arready_s,
    input  rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
    output rready_s
  );

  modport slave (
    input  awid_s, awaddr_s, awlen_s, awsize_s, awburst_s, awvalid_s,
    output awready_s,
    input  wdata_s, wstrb_s, wlast_s, wvalid_s,
    output wready_s,
    output bid_s, bresp_s, bvalid_s,
    input  bready_s,
    input  arid_s, araddr_s, arlen_s, arsize_s, arburst_s, arvalid_s,
    output arready_s,
    output rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
    input  rready_s
  );
endinterface

// File: rtl/axi4_slave_mem_responder.sv
// AXI4 slave serving one burst at a time from a word-addressed single-port SRAM.
// Latency: write beat hits the SRAM in its handshake cycle; first read beat 3 cycles after AR, >=3 cycles per beat.
// Backpressure: AW/AR stall outside IDLE, W always ready in W_DATA, B and R payloads held until ready.
module axi4_slave_mem_responder #(
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int ID_W      = 4,
  parameter  int MEM_BYTES = 65536,
  localparam int MEM_AW    = $clog2(MEM_BYTES / 4)
) (
  input  logic                  clk,
  input  logic                  rst,
  axi4_slave_mem_responder_if.slave axi,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_DATA  = 3'd1,
    W_RESP  = 3'd2,
    R_FETCH = 3'd3,
    R_CAP   = 3'd4,
    R_DATA  = 3'd5
  } state_t;

  localparam logic [1:0]      BURST_INCR  = 2'b01;
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;
  localparam logic [ADDR_W:0] MEM_LIMIT   = (ADDR_W + 1)'(MEM_BYTES);

  // Burst context latched at the address handshake
  state_t              r_state;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [8:0]          r_cnt;
  logic                r_err;
  logic                r_prio_w;

  // Registered response payloads
  logic                r_bvalid;
  logic [ID_W-1:0]     r_bid;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic [ID_W-1:0]     r_rid;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;
  logic                r_rlast;

  logic                w_grant_w;
  logic                w_grant_r;
  logic                w_aw_hs;
  logic                w_ar_hs;
  logic                w_aw_err;
  logic                w_ar_err;
  logic                w_oob;
  logic                w_last;
  logic                w_w_hs;
  logic                w_w_suppress;
  logic                w_wlast_bad;
  logic                w_r_beat_err;
  logic [ADDR_W-1:0]   w_next_addr;

  // An unsupported size or a WRAP/reserved burst poisons the whole burst
  assign w_aw_err = (axi.awsize_s > 3'd2) || axi.awburst_s[1];
  assign w_ar_err = (axi.arsize_s > 3'd2) || axi.arburst_s[1];

  assign w_oob        = ({1'b0, r_addr} >= MEM_LIMIT);
  assign w_last       = (r_cnt == {1'b0, r_len});
  assign w_w_hs       = (r_state == W_DATA) && axi.wvalid_s;
  assign w_w_suppress = r_err || w_oob;
  assign w_wlast_bad  = (axi.wlast_s != w_last);
  assign w_r_beat_err = r_err || w_oob;

  // INCR steps by the beat size and wraps at the top of the address space; FIXED holds
  assign w_next_addr = (r_burst == BURST_INCR) ? (r_addr + (ADDR_W'(1) << r_size)) : r_addr;

  // Round-robin between AW and AR: a lone request wins, a tie goes to the channel not served last
  always_comb begin
    w_grant_w = 1'b0;
    w_grant_r = 1'b0;
    if (axi.awvalid_s && axi.arvalid_s) begin
      w_grant_w = r_prio_w;
      w_grant_r = !r_prio_w;
    end else begin
      w_grant_w = axi.awvalid_s;
      w_grant_r = axi.arvalid_s;
    end
  end

  assign axi.awready_s = (r_state == IDLE) && w_grant_w;
  assign axi.arready_s = (r_state == IDLE) && w_grant_r;
  assign w_aw_hs       = axi.awvalid_s && axi.awready_s;
  assign w_ar_hs       = axi.arvalid_s && axi.arready_s;

  assign axi.wready_s  = (r_state == W_DATA);

  assign axi.bvalid_s  = r_bvalid;
  assign axi.bid_s     = r_bid;
  assign axi.bresp_s   = r_bresp;

  assign axi.rvalid_s  = r_rvalid;
  assign axi.rid_s     = r_rid;
  assign axi.rdata_s   = r_rdata;
  assign axi.rresp_s   = r_rresp;
  assign axi.rlast_s   = r_rlast;

  // SRAM port: write beats go straight through in their handshake cycle, reads are issued in R_FETCH
  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = r_addr[MEM_AW+1:2];
    mem_wdata = '0;
    mem_wstrb = '0;
    if (w_w_hs && !w_w_suppress) begin
      mem_cs    = 1'b1;
      mem_we    = 1'b1;
      mem_wdata = axi.wdata_s;
      mem_wstrb = axi.wstrb_s;
    end else if ((r_state == R_FETCH) && !w_r_beat_err) begin
      mem_cs = 1'b1;
    end
  end

  // Transaction FSM with registered B/R payloads; reset drops any burst in flight silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_prio_w <= 1'b1;
      r_bvalid <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= '0;
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_rlast  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_aw_hs) begin
            r_id     <= axi.awid_s;
            r_addr   <= axi.awaddr_s;
            r_len    <= axi.awlen_s;
            r_size   <= axi.awsize_s;
            r_burst  <= axi.awburst_s;
            r_cnt    <= '0;
            r_err    <= w_aw_err;
            r_prio_w <= 1'b0;
            r_state  <= W_DATA;
          end else if (w_ar_hs) begin
            r_id     <= axi.arid_s;
            r_addr   <= axi.araddr_s;
            r_len    <= axi.arlen_s;
            r_size   <= axi.arsize_s;
            r_burst  <= axi.arburst_s;
            r_cnt    <= '0;
            r_err    <= w_ar_err;
            r_prio_w <= 1'b1;
            r_state  <= R_FETCH;
          end
        end

        W_DATA: begin
          if (axi.wvalid_s) begin
            // The beat count ends the burst; a wlast disagreement only flags the response
            if (w_w_suppress || w_wlast_bad) begin
              r_err <= 1'b1;
            end
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 9'd1;
            if (w_last) begin
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= (w_w_suppress || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              r_state  <= W_RESP;
            end
          end
        end

        W_RESP: begin
          if (axi.bready_s) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end

        R_FETCH: begin
          r_state <= R_CAP;
        end

        R_CAP: begin
          // SRAM data is valid this cycle; error beats return zero instead
          r_rvalid <= 1'b1;
          r_rid    <= r_id;
          r_rdata  <= w_r_beat_err ? '0 : mem_rdata;
          r_rresp  <= w_r_beat_err ? RESP_SLVERR : RESP_OKAY;
          r_rlast  <= w_last;
          r_state  <= R_DATA;
        end

        R_DATA: begin
          if (axi.rready_s) begin
            r_rvalid <= 1'b0;
            if (r_rlast) begin
              r_state <= IDLE;
            end else begin
              r_addr  <= w_next_addr;
              r_cnt   <= r_cnt + 9'd1;
              r_state <= R_FETCH;
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem_responder.sv
// Directed plus randomized bench: drives AXI bursts, models the SRAM, and checks against a word-array reference.
// Latency: checks first read beat lands 3 cycles after AR; write beats hit the SRAM in their handshake cycle.
// Backpressure: R channel is stalled randomly, B is always accepted.
module tb_axi4_slave_mem_responder;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int ID_W      = 4;
  localparam int MEM_BYTES = 65536;
  localparam int MEM_AW    = 14;
  localparam int MEM_WORDS = MEM_BYTES / 4;
  localparam int BUDGET    = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_slave_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  logic              mem_cs;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;

  axi4_slave_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MEM_BYTES(MEM_BYTES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axi(bus),
    .mem_cs(mem_cs),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  // Behavioural SRAM with one-cycle read latency
  logic [31:0] sram [MEM_WORDS] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory contents as the master expects to see them
  logic [31:0] ref_mem [MEM_WORDS] = '{default: 32'h0};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                            input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'(i) << size);
  endfunction

  task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic got = 1'b0;
    bus.awid_s = id; bus.awaddr_s = addr; bus.awlen_s = 8'(len);
    bus.awsize_s = size; bus.awburst_s = burst; bus.awvalid_s = 1'b1;
    for (int n = 0; n < BUDGET && !got; n++) begin
      #1 got = bus.awready_s;
      @(posedge clk); #1;
    end
    bus.awvalid_s = 1'b0;
    chk("aw_accept", got, 1);
  endtask

  task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, output int hs);
    logic got = 1'b0;
    hs = 0;
    bus.arid_s = id; bus.araddr_s = addr; bus.arlen_s = 8'(len);
    bus.arsize_s = size; bus.arburst_s = burst; bus.arvalid_s = 1'b1;
    for (int n = 0; n < BUDGET && !got; n++) begin
      #1 got = bus.arready_s;
      hs = cyc;
      @(posedge clk); #1;
    end
    bus.arvalid_s = 1'b0;
    chk("ar_accept", got, 1);
  endtask

  // Drives all W beats; expectations come from the burst rules applied to the reference array
  task automatic w_phase(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input int early, input bit full_strb,
                         output logic [1:0] exp_bresp);
    logic err = (size > 3'd2) || burst[1];
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a = beat_addr(addr, i, size, burst);
      logic [31:0] d = $urandom;
      logic [3:0]  s = full_strb ? 4'hF : 4'($urandom_range(1, 15));
      logic        wl = (early >= 0) ? (i == early) : (i == len);
      logic        sup = err || (a >= 32'(MEM_BYTES));
      logic        got = 1'b0;
      bus.wdata_s = d; bus.wstrb_s = s; bus.wlast_s = wl; bus.wvalid_s = 1'b1;
      for (int n = 0; n < BUDGET && !got; n++) begin
        #1 got = bus.wready_s;
        if (got) begin
          chk("w_mem_cs", mem_cs, !sup);
          if (!sup) begin
            chk("w_mem_we", mem_we, 1);
            chk("w_mem_addr", mem_addr, a[15:2]);
            chk("w_mem_wdata", mem_wdata, d);
            chk("w_mem_wstrb", mem_wstrb, s);
          end
        end
        @(posedge clk); #1;
      end
      chk("w_accept", got, 1);
      if (!sup)
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[a[15:2]][8*b +: 8] = d[8*b +: 8];
      if (sup || (wl != (i == len))) err = 1'b1;
    end
    bus.wvalid_s = 1'b0;
    bus.wlast_s  = 1'b0;
    exp_bresp = err ? 2'b10 : 2'b00;
  endtask

  task automatic b_phase(input logic [3:0] id, input logic [1:0] exp_bresp);
    logic got = 1'b0;
    for (int n = 0; n < BUDGET && !got; n++) begin
      #1 got = bus.bvalid_s;
      if (got) begin
        chk("b_id", bus.bid_s, id);
        chk("b_resp", bus.bresp_s, exp_bresp);
      end
      @(posedge clk); #1;
    end
    chk("b_seen", got, 1);
  endtask

  // Receives nbeats read beats with random R stalls, checking data against the reference array
  task automatic r_phase(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input int hs,
                         input int nbeats);
    logic berr = (size > 3'd2) || burst[1];
    for (int i = 0; i < nbeats; i++) begin
      logic [31:0] a = beat_addr(addr, i, size, burst);
      logic        e = berr || (a >= 32'(MEM_BYTES));
      logic [31:0] expd = e ? 32'h0 : ref_mem[a[15:2]];
      logic        got = 1'b0;
      int          k = $urandom_range(0, 2);
      bus.rready_s = 1'b0;
      for (int n = 0; n < BUDGET; n++) begin
        #1 got = bus.rvalid_s;
        if (got) break;
        @(posedge clk); #1;
      end
      chk("r_seen", got, 1);
      if (i == 0) chk("r_first_latency", cyc - hs, 3);
      chk("r_id", bus.rid_s, id);
      chk("r_data", bus.rdata_s, expd);
      chk("r_resp", bus.rresp_s, e ? 2'b10 : 2'b00);
      chk("r_last", bus.rlast_s, i == len);
      repeat (k) @(posedge clk);
      #1 chk("r_stable", bus.rdata_s, expd);
      bus.rready_s = 1'b1;
      @(posedge clk); #1;
      bus.rready_s = 1'b0;
    end
  endtask

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int early,
                          input bit full_strb);
    logic [1:0] eb;
    aw_phase(id, addr, len, size, burst);
    w_phase(addr, len, size, burst, early, full_strb, eb);
    b_phase(id, eb);
  endtask

  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    int hs;
    ar_phase(id, addr, len, size, burst, hs);
    r_phase(id, addr, len, size, burst, hs, len + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  eb;
    int          hs;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          len;

    bus.awid_s = '0; bus.awaddr_s = '0; bus.awlen_s = '0; bus.awsize_s = '0; bus.awburst_s = '0;
    bus.awvalid_s = 1'b0;
    bus.wdata_s = '0; bus.wstrb_s = '0; bus.wlast_s = 1'b0; bus.wvalid_s = 1'b0;
    bus.bready_s = 1'b1;
    bus.arid_s = '0; bus.araddr_s = '0; bus.arlen_s = '0; bus.arsize_s = '0; bus.arburst_s = '0;
    bus.arvalid_s = 1'b0;
    bus.rready_s = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", bus.awready_s, 0);
    chk("rst_arready", bus.arready_s, 0);
    chk("rst_wready", bus.wready_s, 0);
    chk("rst_bvalid", bus.bvalid_s, 0);
    chk("rst_rvalid", bus.rvalid_s, 0);
    chk("rst_rdata", bus.rdata_s, 0);
    chk("rst_bid", bus.bid_s, 0);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_we", mem_we, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Basic INCR write then read-back
    wr_burst(4'h5, 32'h100, 3, 3'd2, 2'b01, -1, 1'b1);
    rd_burst(4'h3, 32'h100, 3, 3'd2, 2'b01);

    // Simultaneous AW/AR: write first, then the pending read beats a fresh write
    bus.awid_s = 4'h1; bus.awaddr_s = 32'h400; bus.awlen_s = 8'd1; bus.awsize_s = 3'd2;
    bus.awburst_s = 2'b01; bus.awvalid_s = 1'b1;
    bus.arid_s = 4'h2; bus.araddr_s = 32'h100; bus.arlen_s = 8'd0; bus.arsize_s = 3'd2;
    bus.arburst_s = 2'b01; bus.arvalid_s = 1'b1;
    #1;
    chk("rr1_awready", bus.awready_s, 1);
    chk("rr1_arready", bus.arready_s, 0);
    @(posedge clk); #1;
    bus.awvalid_s = 1'b0;
    w_phase(32'h400, 1, 3'd2, 2'b01, -1, 1'b1, eb);
    bus.awid_s = 4'h9; bus.awaddr_s = 32'h500; bus.awlen_s = 8'd0; bus.awvalid_s = 1'b1;
    b_phase(4'h1, eb);
    #1;
    chk("rr2_arready", bus.arready_s, 1);
    chk("rr2_awready", bus.awready_s, 0);
    hs = cyc;
    @(posedge clk); #1;
    bus.arvalid_s = 1'b0;
    r_phase(4'h2, 32'h100, 0, 3'd2, 2'b01, hs, 1);
    aw_phase(4'h9, 32'h500, 0, 3'd2, 2'b01);
    w_phase(32'h500, 0, 3'd2, 2'b01, -1, 1'b0, eb);
    b_phase(4'h9, eb);
    rd_burst(4'h4, 32'h400, 1, 3'd2, 2'b01);

    // Burst running off the end of the SRAM
    wr_burst(4'h6, 32'(MEM_BYTES - 8), 3, 3'd2, 2'b01, -1, 1'b1);
    rd_burst(4'h6, 32'(MEM_BYTES - 8), 3, 3'd2, 2'b01);

    // Unsupported bursts and sizes, then a premature wlast
    wr_burst(4'h7, 32'h200, 3, 3'd2, 2'b10, -1, 1'b1);
    wr_burst(4'h8, 32'h240, 1, 3'd3, 2'b01, -1, 1'b1);
    wr_burst(4'hA, 32'h260, 1, 3'd2, 2'b11, -1, 1'b1);
    rd_burst(4'hB, 32'h100, 1, 3'd2, 2'b10);
    wr_burst(4'hC, 32'h300, 3, 3'd2, 2'b01, 1, 1'b1);
    rd_burst(4'hC, 32'h300, 3, 3'd2, 2'b01);
    rd_burst(4'hD, 32'h200, 3, 3'd2, 2'b01);

    // Longest burst
    wr_burst(4'hE, 32'h1000, 255, 3'd2, 2'b01, -1, 1'b0);
    rd_burst(4'hE, 32'h1000, 255, 3'd2, 2'b01);

    // Randomized write/read-back pairs
    for (int t = 0; t < 16; t++) begin
      size  = (t % 3 == 0) ? 3'($urandom_range(0, 2)) : 3'd2;
      burst = 2'($urandom_range(0, 1));
      len   = $urandom_range(0, 15);
      addr  = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
      if (t % 5 == 0) addr = 32'(MEM_BYTES) - (32'($urandom_range(1, 8)) << 2);
      wr_burst(4'(t), addr, len, size, burst, -1, 1'b0);
      rd_burst(4'(t + 1), addr, len, size, burst);
    end

    // Reset in the middle of an 8-beat read
    ar_phase(4'h7, 32'h100, 7, 3'd2, 2'b01, hs);
    r_phase(4'h7, 32'h100, 7, 3'd2, 2'b01, hs, 2);
    chk("mid_fetch_mem_cs", mem_cs, 1);
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid_rvalid_before_rst", bus.rvalid_s, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", bus.rvalid_s, 0);
    chk("mid_rst_mem_cs", mem_cs, 0);
    chk("mid_rst_rdata", bus.rdata_s, 0);
    chk("mid_rst_rlast", bus.rlast_s, 0);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rvalid", bus.rvalid_s, 0);
    rd_burst(4'h2, 32'h104, 0, 3'd2, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
